// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//
// Purpose:
//   Sequential unsigned restoring divider. One quotient bit is resolved per
//   clock, so a division takes WIDTH iterations after the start is accepted.
//   A divisor of zero skips the iterations and completes immediately with a
//   flagged, saturated result.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   request a new division (accepted only when busy=0)
//   dividend     in   [WIDTH-1:0] unsigned dividend, sampled on accept
//   divisor      in   [WIDTH-1:0] unsigned divisor, sampled on accept
//   busy         out  high while iterating (state RUN)
//   done         out  one-cycle pulse when the result registers are updated
//   quotient     out  [WIDTH-1:0] last completed quotient
//   remainder    out  [WIDTH-1:0] last completed remainder
//   div_by_zero  out  last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;        // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out / quotient in
    logic [WIDTH-1:0] m_q, m_d;        // latched divisor
    logic [CW-1:0]    cnt_q, cnt_d;    // iterations still to run
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // One restoring step on the current {A,Q}.
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        a_shift = (a_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
        trial   = a_shift - {1'b0, m_q};
        // A negative trial means the divisor did not fit: keep the shifted
        // value (the restore) and shift in a 0 quotient bit.
        a_next  = trial[WIDTH] ? a_shift : trial;
        q_next  = (q_q << 1) | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Zero divisor completes without iterating.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        m_d     = divisor;
                        a_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_next;
                    rem_d   = a_next[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
//
// Self-checking bench for restoring_divider (WIDTH=8). Expected results come
// from plain integer division; timing expectations come from the documented
// latency (done after WIDTH iterations, or immediately for a zero divisor).
// -----------------------------------------------------------------------------
module tb_restoring_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int total_cnt;
    int bad_cnt;

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << WIDTH) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Runs one division. Must be entered right after a falling edge; returns
    // right after a falling edge. With noisy=1 a second start (9/3) is held
    // during RUN and must be ignored.
    task automatic do_op(input int a, input int b, input bit noisy,
                         input string tag);
        int eq, er, ez;
        int n;
        int busy_seen;
        int extra_done;
        int extra_busy;
        int held_bad;
        int watch;
        ref_div(a, b, eq, er, ez);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(negedge clk);                 // edge 0 has accepted the start
        start     = 1'b0;
        n         = 0;
        busy_seen = 0;
        while (!done && n < 40) begin
            if (busy) busy_seen++;
            if (noisy) begin
                start    = (n < 6);
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, int'(done), 1);
        check({tag, " latency"}, n, (b == 0) ? 0 : WIDTH);
        check({tag, " busy_cycles"}, busy_seen, (b == 0) ? 0 : WIDTH);
        check({tag, " quotient"}, int'(quotient), eq);
        check({tag, " remainder"}, int'(remainder), er);
        check({tag, " div_by_zero"}, int'(div_by_zero), ez);
        watch      = noisy ? 12 : 3;
        extra_done = 0;
        extra_busy = 0;
        held_bad   = 0;
        for (int i = 0; i < watch; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
            if (int'(quotient) != eq || int'(remainder) != er ||
                int'(div_by_zero) != ez) held_bad++;
        end
        check({tag, " extra_done"}, extra_done, 0);
        check({tag, " idle_busy"}, extra_busy, 0);
        check({tag, " held"}, held_bad, 0);
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                 tag, a, b, quotient, remainder, div_by_zero, n);
    endtask

    initial begin
        int a, b;
        int n;
        int hold_bad;
        int extra_done;
        total_cnt = 0;
        bad_cnt   = 0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        reset     = 1'b1;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset dbz", int'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // First start on the very first edge after reset release.
        do_op(100, 7, 1'b0, "100/7");
        do_op(255, 1, 1'b0, "255/1");
        do_op(5, 9, 1'b0, "5/9");
        do_op(200, 200, 1'b0, "200/200");
        do_op(77, 0, 1'b0, "77/0");
        do_op(100, 7, 1'b1, "100/7_noisy");

        // Start held high: back-to-back operations every WIDTH+1 cycles.
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check("b2b first_done", int'(done), 1);
        for (int k = 0; k < 3; k++) begin
            check("b2b quotient", int'(quotient), 10);
            check("b2b remainder", int'(remainder), 0);
            n        = 0;
            hold_bad = 0;
            do begin
                @(negedge clk);
                n++;
                if (int'(quotient) != 10 || int'(remainder) != 0 ||
                    div_by_zero != 1'b0) hold_bad++;
            end while (!done && n < 40);
            check("b2b period", n, WIDTH + 1);
            check("b2b held", hold_bad, 0);
            $display("b2b %0d: 50/5 -> q=%0d r=%0d period=%0d",
                     k, quotient, remainder, n);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN, asserted away from any clock edge.
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort quotient", int'(quotient), 0);
        check("abort remainder", int'(remainder), 0);
        check("abort dbz", int'(div_by_zero), 0);
        $display("abort: reset mid-run -> busy=%0d q=%0d r=%0d",
                 busy, quotient, remainder);
        @(negedge clk);
        reset = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("abort no_done", extra_done, 0);
        do_op(100, 7, 1'b0, "100/7_after_abort");

        // Randomized operations, including occasional zero divisors.
        for (int t = 0; t < 30; t++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            do_op(a, b, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is WIDTH >= 2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a new division.
REQ-005 The module SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled when start is accepted.
REQ-006 The module SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while iterating.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The module SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-010 The module SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: registered flag for a divisor of 0; valid together with the result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Start acceptance SHALL work as follows: start is accepted only in IDLE or DONE (busy=0); start seen in RUN is ignored with no queuing.
REQ-014 On accept with divisor != 0, the block SHALL do all of the following:
- latch M=divisor;
- set A=0 ((WIDTH+1) bits) and Q=dividend;
- set the counter to WIDTH;
- go to RUN.
REQ-015 On accept with divisor == 0, the block SHALL go directly to DONE and load the following results:
- quotient = all ones;
- remainder = dividend;
- div_by_zero = 1.
REQ-016 Each RUN edge SHALL perform one iteration:
- shift {A,Q} left by 1;
- form T = A - {1'b0,M} at WIDTH+1 bits;
- if the MSB of T is 1: restore (A unchanged after the shift) and set Q[0]=0;
- otherwise: set A=T and Q[0]=1;
- decrement the counter.
REQ-017 On the RUN edge that decrements the counter to 0, the block SHALL do all of the following:
- load quotient=Q_next;
- load remainder=A_next[WIDTH-1:0];
- load div_by_zero=0;
- go to DONE.
REQ-018 Latency SHALL be as follows:
- start accepted at edge 0;
- done is high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after start;
- for the divide-by-zero case, done is high in the cycle after edge 0.
REQ-019 done SHALL be high only in DONE, for exactly one cycle.
REQ-020 DONE SHALL go to IDLE on the next edge, unless start is high, in which case a new operation is accepted (back-to-back).
REQ-021 busy SHALL equal (state==RUN) and SHALL be purely registered-state derived.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last completed values, through IDLE and RUN, until the next completion loads them.
REQ-023 Changes to dividend or divisor during RUN SHALL have no effect.
REQ-024 The arithmetic results SHALL satisfy, for divisor != 0: dividend == quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-025 Asserting reset SHALL immediately force all of the following, regardless of clk:
- state=IDLE;
- busy=0 and done=0;
- quotient=0, remainder=0 and div_by_zero=0;
- A, Q, M and the counter cleared.
REQ-026 A reset asserted mid-RUN SHALL abort the operation, and no done SHALL follow.
REQ-027 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-028 The bench SHALL cover these directed scenarios (WIDTH=8):
- 100/7, start for 1 cycle -> busy for 8 cycles; done in cycle 9; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 200/200 -> quotient=1, remainder=0.
- 77/0 -> done in cycle 1 after start; quotient=8'hFF, remainder=77, div_by_zero=1; busy never high.
- Start 100/7, then start=1 with 9/3 held during RUN -> only 100/7 completes (14, 2); exactly one done pulse.
- Start held high continuously with 50/5 -> done every 9 cycles; quotient=10, remainder=0 each time; results held between completions.
- Reset asserted at RUN cycle 4 of 100/7 -> busy, done, quotient and remainder go to 0 without a clock edge; no done after release; next 100/7 completes normally.
